ps2_mouse_packer: RTL



---
 rtl/ps2_mouse_pkg.sv | 24 ++
 rtl/ps2_byte_timer.sv | 36 +++
 rtl/ps2_mouse_packer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packer.
// Packet length depends on PS2_MOUSE_WHEEL_EN (4-byte IntelliMouse packets when defined).
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2,
        S_B3 = 2'd3
    } ps2_state_e;

    localparam int unsigned STAT_LSB   = 0;
    localparam int unsigned DX_LSB     = 8;
    localparam int unsigned DY_LSB     = 16;
    localparam int unsigned TOGGLE_BIT = 24;
    localparam int unsigned SYNC_BIT   = 3;

`ifdef PS2_MOUSE_WHEEL_EN
    localparam int unsigned PKT_LEN = 4;
`else
    localparam int unsigned PKT_LEN = 3;
`endif

endpackage

// File: rtl/ps2_byte_timer.sv
// Inter-byte timeout counter: expires when TIMEOUT_CYCLES-1 is reached while running.
module ps2_byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = run && !clear && (cnt_q == LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_mouse_packer.sv
// Frames PS/2 mouse bytes into the packed {toggle, dy, dx, status} word.
// Optional wheel support via PS2_MOUSE_WHEEL_EN.
module ps2_mouse_packer
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic [24:0]      ps2_mouse,
    output logic [7:0]       ps2_wheel,
    output logic             sync_err,
    output logic [CNT_W-1:0] drop_cnt
);

    ps2_state_e       state_q, state_d;
    logic [7:0]       stat_q, stat_d;
    logic [7:0]       dx_q, dx_d;
    logic [7:0]       dy_q, dy_d;
    logic [24:0]      mouse_q, mouse_d;
    logic             sync_err_q, sync_err_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             drop_inc;
    logic             tmr_clear, tmr_run, tmr_expire;

    assign tmr_clear = byte_valid || (state_q == S_B0);
    assign tmr_run   = !tmr_clear;

    ps2_byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_sys(clk_sys),
        .reset  (reset),
        .clear  (tmr_clear),
        .run    (tmr_run),
        .expire (tmr_expire)
    );

`ifdef PS2_MOUSE_WHEEL_EN
    logic [7:0] wheel_q, wheel_d;
`endif

    always_comb begin
        state_d    = state_q;
        stat_d     = stat_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        mouse_d    = mouse_q;
        sync_err_d = 1'b0;
        drop_inc   = 1'b0;
`ifdef PS2_MOUSE_WHEEL_EN
        wheel_d    = wheel_q;
`endif
        if (byte_valid) begin
            case (state_q)
                S_B0: begin
                    if (byte_data[SYNC_BIT]) begin
                        stat_d  = byte_data;
                        state_d = S_B1;
                    end else begin
                        sync_err_d = 1'b1;
                        drop_inc   = 1'b1;
                    end
                end
                S_B1: begin
                    dx_d    = byte_data;
                    state_d = S_B2;
                end
                S_B2: begin
                    dy_d = byte_data;
`ifdef PS2_MOUSE_WHEEL_EN
                    state_d = S_B3;
`else
                    // Whole word and toggle load together so the consumer never sees a mix.
                    mouse_d[STAT_LSB +: 8] = stat_q;
                    mouse_d[DX_LSB +: 8]   = dx_q;
                    mouse_d[DY_LSB +: 8]   = byte_data;
                    mouse_d[TOGGLE_BIT]    = ~mouse_q[TOGGLE_BIT];
                    state_d                = S_B0;
`endif
                end
`ifdef PS2_MOUSE_WHEEL_EN
                S_B3: begin
                    mouse_d[STAT_LSB +: 8] = stat_q;
                    mouse_d[DX_LSB +: 8]   = dx_q;
                    mouse_d[DY_LSB +: 8]   = dy_q;
                    mouse_d[TOGGLE_BIT]    = ~mouse_q[TOGGLE_BIT];
                    wheel_d                = byte_data;
                    state_d                = S_B0;
                end
`endif
                default: state_d = S_B0;
            endcase
        end else if (tmr_expire) begin
            state_d    = S_B0;
            sync_err_d = 1'b1;
            drop_inc   = 1'b1;
        end

        drop_d = drop_q;
        if (drop_inc && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_B0;
            stat_q     <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            mouse_q    <= '0;
            sync_err_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            stat_q     <= stat_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            mouse_q    <= mouse_d;
            sync_err_q <= sync_err_d;
            drop_q     <= drop_d;
        end
    end

`ifdef PS2_MOUSE_WHEEL_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wheel_q <= '0;
        end else begin
            wheel_q <= wheel_d;
        end
    end
    assign ps2_wheel = wheel_q;
`else
    assign ps2_wheel = 8'h00;
`endif

    assign ps2_mouse = mouse_q;
    assign sync_err  = sync_err_q;
    assign drop_cnt  = drop_q;

endmodule
